// File: rtl/seq_nonrestoring_div.sv
// Sequential signed divider: non-restoring, one quotient bit per cycle.
// Truncating semantics with divide-by-zero and overflow flags.
module seq_nonrestoring_div #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic         ovf
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t state;
  logic [CW-1:0] cnt;
  logic [N-1:0] a_reg;
  logic [N-1:0] dm;
  logic [N-1:0] qa;
  logic [N:0] p;
  logic a_neg;
  logic d_neg;

  logic [N-1:0] a_mag;
  logic [N-1:0] d_mag;
  logic [N:0] p_sh;
  logic [N:0] p_nx;
  logic [N-1:0] r_mag;
  logic [N-1:0] q_sgn;
  logic [N-1:0] r_sgn;
  logic is_dz;
  logic is_ovf;

  // Magnitudes as unsigned N-bit values; -2^(N-1) maps to 2^(N-1).
  assign a_mag = a[N-1] ? (~a + ONE) : a;
  assign d_mag = d[N-1] ? (~d + ONE) : d;

  // The next partial remainder always fits in N+1 bits, so the
  // arithmetic is done modulo 2^(N+1).
  assign p_sh = {p[N-1:0], qa[N-1]};
  assign p_nx = p[N] ? (p_sh + {1'b0, dm}) : (p_sh - {1'b0, dm});

  assign r_mag = p[N] ? (p[N-1:0] + dm) : p[N-1:0];
  assign q_sgn = (a_neg ^ d_neg) ? (~qa + ONE) : qa;
  assign r_sgn = a_neg ? (~r_mag + ONE) : r_mag;
  assign is_dz = (dm == '0);
  assign is_ovf = (a_reg == MIN_NEG) && d_neg && (dm == ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_reg <= '0;
      dm    <= '0;
      qa    <= '0;
      p     <= '0;
      a_neg <= 1'b0;
      d_neg <= 1'b0;
      q     <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            a_neg <= a[N-1];
            d_neg <= d[N-1];
            qa    <= a_mag;
            dm    <= d_mag;
            p     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          p   <= p_nx;
          qa  <= {qa[N-2:0], ~p_nx[N]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (is_dz) begin
            q <= '1;
            r <= a_reg;
          end else begin
            q <= q_sgn;
            r <= r_sgn;
          end
          dz    <= is_dz;
          ovf   <= is_ovf;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_nonrestoring_div.sv
// Scoreboard bench for seq_nonrestoring_div (N=32).
// Driver pushes expectations; a negedge monitor checks each done pulse.
module tb_seq_nonrestoring_div;

  localparam int N = 32;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] d = '0;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic busy;
  logic done;
  logic dz;
  logic ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t sb[$];

  seq_nonrestoring_div #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .d    (d),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .dz   (dz),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("q", 64'(q), 64'(e.q));
        chk("r", 64'(r), 64'(e.r));
        chk("dz", 64'(dz), 64'(e.dz));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [N-1:0] ta, input logic [N-1:0] td,
                     input logic [N-1:0] eq, input logic [N-1:0] er,
                     input logic edz, input logic eovf);
    exp_t e;
    @(negedge clk);
    a = ta;
    d = td;
    start = 1'b1;
    e.q = eq;
    e.r = er;
    e.dz = edz;
    e.ovf = eovf;
    e.cyc = cyc + N + 2;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_calc", 64'(busy), 64'd1);
    a = 32'hDEADBEEF;
    d = 32'h00000005;
    wait_drain();
  endtask

  initial begin
    exp_t e;
    int c0;
    repeat (2) @(negedge clk);
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    run(-32'd100, 32'd7, -32'd14, -32'd2, 1'b0, 1'b0);
    run(32'd100, -32'd7, -32'd14, 32'd2, 1'b0, 1'b0);
    run(-32'd100, -32'd7, 32'd14, -32'd2, 1'b0, 1'b0);
    run(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1);
    run(32'h80000000, 32'd1, 32'h80000000, 32'd0, 1'b0, 1'b0);
    run(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0);
    run(-32'd9, 32'd0, 32'hFFFFFFFF, -32'd9, 1'b1, 1'b0);
    run(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    run(32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 1'b0);
    run(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1'b0);
    run(-32'd1, 32'h80000000, 32'd0, -32'd1, 1'b0, 1'b0);
    run(32'h80000000, 32'h80000000, 32'd1, 32'd0, 1'b0, 1'b0);
    run(32'h7FFFFFFF, -32'd1, 32'h80000001, 32'd0, 1'b0, 1'b0);

    // start held high: back-to-back results every N+3 cycles
    @(negedge clk);
    a = 32'd1000;
    d = 32'd3;
    start = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      e.q = 32'd333;
      e.r = 32'd1;
      e.dz = 1'b0;
      e.ovf = 1'b0;
      e.cyc = c0 + N + 2 + i * (N + 3);
      sb.push_back(e);
    end
    repeat (10) @(negedge clk);
    a = 32'd77;
    d = 32'd0;
    repeat (10) @(negedge clk);
    a = 32'd1000;
    d = 32'd3;
    repeat (3 * N + 8 - 20) @(negedge clk);
    start = 1'b0;
    wait_drain();

    // reset in the middle of CALC aborts with no done pulse
    @(negedge clk);
    a = 32'd1000;
    d = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_q", 64'(q), 64'd0);
    chk("abort_r", 64'(r), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_flags", 64'({dz, ovf}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("abort_idle_busy", 64'(busy), 64'd0);

    run(-32'd7, 32'd2, -32'd3, -32'd1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
